// File: rtl/decode_fwd_stage.sv
// decode_fwd_stage
//   Decode-stage instruction register with load-use stall detection and
//   combinational operand forwarding from the EX, MEM and WB stages.
//
//   Parameters
//     XLEN      operand data width
//     FWD_SRCS  forwarding sources enabled: 1 = EX, 2 = EX+MEM, 3 = EX+MEM+WB
//     NOP       bubble instruction loaded on flush / invalid fetch
//     CNT_W     stall-counter width
//
//   Ports
//     clk, rst                      clock (rising edge), async active-high reset
//     ins_dec_in, ins_vld_in        fetched instruction and its valid
//     flush                         taken-branch kill, beats stall
//     ex_*/mem_*/wb_*               writer info of the later pipeline stages
//     rso1, rso2                    register-file read data
//     ins_dec_out, ins_vld_out      held instruction and its valid
//     rs1, rs2                      register-file read addresses
//     alu_in1, alu_in2              forwarded operands
//     stall_out                     fetch hold (load-use hazard)
//     issue_vld                     instruction handed to EX this cycle
//     stall_cnt                     stall-cycle count
//
//   Build option
//     DECODE_STALL_CNT_EN  when defined, stall_cnt is a saturating counter of
//                          stalled (non-flushed) cycles; otherwise tied to 0.

// One operand's forwarding mux. Sources are ordered youngest first
// (0 = EX, 1 = MEM, 2 = WB) so the lowest matching index wins.
module decode_fwd_operand #(
    parameter int XLEN     = 32,
    parameter int NSRC     = 3,
    parameter int FWD_SRCS = 3
) (
    input  logic [4:0]                 rs,
    input  logic [XLEN-1:0]            rso,
    input  logic [NSRC-1:0]            src_en,
    input  logic [NSRC-1:0][4:0]       src_rd,
    input  logic [NSRC-1:0][XLEN-1:0]  src_res,
    output logic [XLEN-1:0]            alu_in
);

    always_comb begin
        alu_in = rso;
        // Walk oldest to youngest so a younger match overrides an older one.
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (s < FWD_SRCS && src_en[s] && src_rd[s] == rs)
                alu_in = src_res[s];
        end
        // x0 reads as zero whatever the sources say.
        if (rs == 5'd0)
            alu_in = '0;
    end

endmodule

module decode_fwd_stage #(
    parameter int          XLEN     = 32,
    parameter int          FWD_SRCS = 3,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins_dec_in,
    input  logic             ins_vld_in,
    input  logic             flush,
    input  logic             ex_w_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_w_en,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_w_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    input  logic [XLEN-1:0]  rso1,
    input  logic [XLEN-1:0]  rso2,
    output logic [31:0]      ins_dec_out,
    output logic             ins_vld_out,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic             stall_out,
    output logic             issue_vld,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int NSRC    = 3;
    localparam int NUM_OPS = 2;

    // ------------------------------------------------------------------
    // Decode register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_dec_out <= NOP;
            ins_vld_out <= 1'b0;
        end else if (flush) begin
            ins_dec_out <= NOP;
            ins_vld_out <= 1'b0;
        end else if (!stall_out) begin
            ins_dec_out <= ins_vld_in ? ins_dec_in : NOP;
            ins_vld_out <= ins_vld_in;
        end
    end

    assign rs1 = ins_dec_out[19:15];
    assign rs2 = ins_dec_out[24:20];

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EX has no data yet, so a dependent
    // instruction waits one cycle and picks the value up from MEM. With
    // only EX forwarding the hold simply lasts as long as the match does.
    // ------------------------------------------------------------------
    assign stall_out = ins_vld_out && ex_w_en && ex_is_load && (ex_rd != 5'd0) &&
                       ((ex_rd == rs1) || (ex_rd == rs2));
    assign issue_vld = ins_vld_out && !stall_out;

    // ------------------------------------------------------------------
    // Forwarding sources. A load in EX is not a source: its result is
    // the address, not the data.
    // ------------------------------------------------------------------
    logic [NSRC-1:0]            src_en;
    logic [NSRC-1:0][4:0]       src_rd;
    logic [NSRC-1:0][XLEN-1:0]  src_res;

    assign src_en  = {wb_w_en  && (wb_rd  != 5'd0),
                      mem_w_en && (mem_rd != 5'd0),
                      ex_w_en  && !ex_is_load && (ex_rd != 5'd0)};
    assign src_rd  = {wb_rd, mem_rd, ex_rd};
    assign src_res = {wb_result, mem_result, ex_result};

    logic [NUM_OPS-1:0][4:0]      rs_idx;
    logic [NUM_OPS-1:0][XLEN-1:0] rso_v;
    logic [NUM_OPS-1:0][XLEN-1:0] alu_v;

    assign rs_idx = {rs2, rs1};
    assign rso_v  = {rso2, rso1};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        decode_fwd_operand #(
            .XLEN     (XLEN),
            .NSRC     (NSRC),
            .FWD_SRCS (FWD_SRCS)
        ) u_fwd (
            .rs      (rs_idx[g]),
            .rso     (rso_v[g]),
            .src_en  (src_en),
            .src_rd  (src_rd),
            .src_res (src_res),
            .alu_in  (alu_v[g])
        );
    end

    assign alu_in1 = alu_v[0];
    assign alu_in2 = alu_v[1];

    // ------------------------------------------------------------------
    // Stall counter. A flushed stall cycle is not counted since the
    // stalled instruction is being discarded anyway.
    // ------------------------------------------------------------------
`ifdef DECODE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (stall_out && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Bench for decode_fwd_stage. Three instances share one stimulus:
//   0: FWD_SRCS=3, CNT_W=16   1: FWD_SRCS=1, CNT_W=2   2: FWD_SRCS=2, CNT_W=16
// Because the stall rule does not depend on FWD_SRCS, all three hold the same
// decode state; only operand selection and counter saturation differ.
module tb_decode_fwd_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_dec_in;
    logic        ins_vld_in, flush;
    logic        ex_w_en, ex_is_load, mem_w_en, wb_w_en;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_result, mem_result, wb_result, rso1, rso2;

    logic [31:0] ins_o [3];
    logic        vld_o [3];
    logic [4:0]  rs1_o [3];
    logic [4:0]  rs2_o [3];
    logic [31:0] a1_o  [3];
    logic [31:0] a2_o  [3];
    logic        st_o  [3];
    logic        iss_o [3];
    logic [15:0] cnt_o [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int FS = (g == 0) ? 3 : ((g == 1) ? 1 : 2);
        localparam int CW = (g == 1) ? 2 : 16;
        logic [CW-1:0] c;
        decode_fwd_stage #(.XLEN(32), .FWD_SRCS(FS), .NOP(NOP), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst),
            .ins_dec_in(ins_dec_in), .ins_vld_in(ins_vld_in), .flush(flush),
            .ex_w_en(ex_w_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
            .mem_w_en(mem_w_en), .mem_rd(mem_rd), .mem_result(mem_result),
            .wb_w_en(wb_w_en), .wb_rd(wb_rd), .wb_result(wb_result),
            .rso1(rso1), .rso2(rso2),
            .ins_dec_out(ins_o[g]), .ins_vld_out(vld_o[g]),
            .rs1(rs1_o[g]), .rs2(rs2_o[g]),
            .alu_in1(a1_o[g]), .alu_in2(a2_o[g]),
            .stall_out(st_o[g]), .issue_vld(iss_o[g]),
            .stall_cnt(c)
        );
        assign cnt_o[g] = 16'(c);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int fs_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic int cmax(input int i);
        return (i == 1) ? 3 : 65535;
    endfunction

    // Operand the instruction must see, from the selection rules.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rso, input int n);
        if (rs == 5'd0) return 32'd0;
        if (ex_w_en && !ex_is_load && ex_rd == rs) return ex_result;
        if (n >= 2 && mem_w_en && mem_rd == rs) return mem_result;
        if (n == 3 && wb_w_en && wb_rd == rs) return wb_result;
        return rso;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
        return {7'h00, r2, r1, 3'h0, 5'd7, 7'h33};
    endfunction

    // ------------------------------------------------------------------
    // Reference model + per-cycle compare (outputs sampled at negedge,
    // inputs only change just after posedge).
    // ------------------------------------------------------------------
    logic [31:0] m_ins;
    logic        m_vld;
    int          m_cnt [3];

    initial begin
        logic [4:0] e1, e2;
        logic       es;
        m_ins = NOP; m_vld = 1'b0; m_cnt = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ins = NOP; m_vld = 1'b0; m_cnt = '{0, 0, 0};
            end
            e1 = m_ins[19:15];
            e2 = m_ins[24:20];
            es = m_vld && ex_w_en && ex_is_load && ex_rd != 5'd0 && (ex_rd == e1 || ex_rd == e2);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("ins%0d", i), ins_o[i], m_ins);
                chk($sformatf("vld%0d", i), 32'(vld_o[i]), 32'(m_vld));
                chk($sformatf("rs1_%0d", i), 32'(rs1_o[i]), 32'(e1));
                chk($sformatf("rs2_%0d", i), 32'(rs2_o[i]), 32'(e2));
                chk($sformatf("stall%0d", i), 32'(st_o[i]), 32'(es));
                chk($sformatf("issue%0d", i), 32'(iss_o[i]), 32'(m_vld && !es));
                chk($sformatf("cnt%0d", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
                if (m_vld) begin
                    chk($sformatf("alu1_%0d", i), a1_o[i], fwd(e1, rso1, fs_of(i)));
                    chk($sformatf("alu2_%0d", i), a2_o[i], fwd(e2, rso2, fs_of(i)));
                end
            end
            if (!rst) begin
`ifdef DECODE_STALL_CNT_EN
                for (int i = 0; i < 3; i++)
                    if (es && !flush && m_cnt[i] < cmax(i)) m_cnt[i]++;
`endif
                if (flush) begin
                    m_ins = NOP; m_vld = 1'b0;
                end else if (!es) begin
                    m_ins = ins_vld_in ? ins_dec_in : NOP;
                    m_vld = ins_vld_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_src;
        ex_w_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        mem_w_en = 0; mem_rd = 0; mem_result = 0;
        wb_w_en = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic set_load3;
        ex_w_en = 1; ex_is_load = 1; ex_rd = 5'd3; ex_result = 32'hDEAD;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] c_exp0, c_exp1;
        rst = 1; ins_dec_in = 0; ins_vld_in = 0; flush = 0;
        rso1 = 0; rso2 = 0;
        clr_src();

        // Reset state
        tick(); tick(); #1;
        chk("rst_ins", ins_o[0], NOP);
        chk("rst_vld", 32'(vld_o[0]), 32'd0);
        chk("rst_stall", 32'(st_o[0]), 32'd0);
        chk("rst_issue", 32'(iss_o[0]), 32'd0);
        chk("rst_rs1", 32'(rs1_o[0]), 32'd0);
        chk("rst_cnt", 32'(cnt_o[0]), 32'd0);

        @(posedge clk); #1;
        rst = 0;
        ins_dec_in = mk(5'd5, 5'd0); ins_vld_in = 1;
        tick();

        // EX beats MEM; x0 never forwarded
        ex_w_en = 1; ex_rd = 5'd5; ex_result = 32'hAA;
        mem_w_en = 1; mem_rd = 5'd5; mem_result = 32'hBB;
        wb_w_en = 1; wb_rd = 5'd0; wb_result = 32'h55;
        rso1 = 32'h11; rso2 = 32'h77;
        #1;
        chk("ex_over_mem", a1_o[0], 32'hAA);
        chk("x0_zero", a2_o[0], 32'h0);
        chk("ex_fwd1", a1_o[1], 32'hAA);
        ex_w_en = 0; wb_rd = 5'd5;
        #1;
        chk("mem_fwd", a1_o[0], 32'hBB);
        chk("mem_fwd2", a1_o[2], 32'hBB);
        chk("mem_nofwd1", a1_o[1], 32'h11);
        mem_w_en = 0;
        #1;
        chk("wb_fwd", a1_o[0], 32'h55);
        chk("wb_nofwd1", a1_o[1], 32'h11);
        chk("wb_nofwd2", a1_o[2], 32'h11);

        // Load-use stall lasts one cycle, then MEM forwards
        tick();
        clr_src();
        ins_dec_in = mk(5'd3, 5'd0);
        tick();
        set_load3();
        ins_dec_in = mk(5'd9, 5'd9);
        #1;
        chk("lu_stall", 32'(st_o[0]), 32'd1);
        chk("lu_issue", 32'(iss_o[0]), 32'd0);
        tick();
        clr_src();
        mem_w_en = 1; mem_rd = 5'd3; mem_result = 32'hCC; rso1 = 32'h11;
        #1;
        chk("lu_held", ins_o[0], mk(5'd3, 5'd0));
        chk("lu_nostall", 32'(st_o[0]), 32'd0);
        chk("lu_issue2", 32'(iss_o[0]), 32'd1);
        chk("lu_memfwd", a1_o[0], 32'hCC);
        chk("lu_nofwd1", a1_o[1], 32'h11);
`ifdef DECODE_STALL_CNT_EN
        chk("lu_cnt", 32'(cnt_o[0]), 32'd1);
`else
        chk("lu_cnt", 32'(cnt_o[0]), 32'd0);
`endif

        // Flush beats stall
        clr_src();
        set_load3();
        flush = 1;
        #1;
        chk("fl_stall", 32'(st_o[0]), 32'd1);
        tick();
        flush = 0;
        #1;
        chk("fl_ins", ins_o[0], 32'h0000_0013);
        chk("fl_vld", 32'(vld_o[0]), 32'd0);
        chk("fl_stall2", 32'(st_o[0]), 32'd0);

        // Four more stalls: 5 total, 2-bit counter saturates at 3
        repeat (4) begin
            clr_src();
            ins_dec_in = mk(5'd3, 5'd0);
            tick();
            set_load3();
            #1;
            chk("sat_stall", 32'(st_o[0]), 32'd1);
            tick();
        end
        clr_src();
        #1;
`ifdef DECODE_STALL_CNT_EN
        c_exp0 = 32'd5; c_exp1 = 32'd3;
`else
        c_exp0 = 32'd0; c_exp1 = 32'd0;
`endif
        chk("sat_cnt16", 32'(cnt_o[0]), c_exp0);
        chk("sat_cnt2", 32'(cnt_o[1]), c_exp1);

        // Asynchronous reset mid-stall
        set_load3();
        #1;
        chk("ar_stall", 32'(st_o[0]), 32'd1);
        rst = 1;
        #1;
        chk("ar_ins", ins_o[0], NOP);
        chk("ar_vld", 32'(vld_o[0]), 32'd0);
        chk("ar_stall2", 32'(st_o[0]), 32'd0);
        chk("ar_issue", 32'(iss_o[0]), 32'd0);
        chk("ar_rs1", 32'(rs1_o[0]), 32'd0);
        chk("ar_cnt", 32'(cnt_o[1]), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        clr_src();
        ins_dec_in = mk(5'd6, 5'd2); ins_vld_in = 1;
        tick();
        chk("post_rst_ins", ins_o[0], mk(5'd6, 5'd2));
        chk("post_rst_vld", 32'(vld_o[0]), 32'd1);

        // Randomized traffic on a small register set to provoke hazards
        repeat (3000) begin
            r = $urandom;
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            ins_dec_in = r;
            ins_vld_in = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            ex_w_en    = 1'($urandom_range(0, 1));
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            ex_result  = $urandom;
            mem_w_en   = 1'($urandom_range(0, 1));
            mem_rd     = 5'($urandom_range(0, 3));
            mem_result = $urandom;
            wb_w_en    = 1'($urandom_range(0, 1));
            wb_rd      = 5'($urandom_range(0, 3));
            wb_result  = $urandom;
            rso1       = $urandom;
            rso2       = $urandom;
            tick();
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
